// File: rtl/tdp_ram_be.sv
// Single-clock true dual-port RAM with byte enables, read-during-write modes,
// cross-port collision detect/count and post-reset clear sweep. Option: TDP_RAM_OUT_REG_EN.
module tdp_ram_be #(
  parameter int                 WIDTH    = 32,
  parameter int                 DEPTH    = 16,
  parameter int                 ADDR     = $clog2(DEPTH),
  parameter int                 RD_MODE  = 0,
  parameter logic [WIDTH-1:0]   INIT_VAL = '0,
  parameter int                 NB       = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NB-1:0]     wea,
  input  logic [ADDR-1:0]   addra,
  input  logic [WIDTH-1:0]  dina,
  output logic [WIDTH-1:0]  douta,
  input  logic              enb,
  input  logic [NB-1:0]     web,
  input  logic [ADDR-1:0]   addrb,
  input  logic [WIDTH-1:0]  dinb,
  output logic [WIDTH-1:0]  doutb,
  output logic              init_busy,
  output logic              coll,
  output logic [15:0]       coll_cnt
);

  localparam logic [ADDR-1:0] LAST    = ADDR'(DEPTH - 1);
  localparam logic [ADDR:0]   DEPTH_L = (ADDR + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              run;
  logic              a_ok, b_ok, wr_a, wr_b;
  logic [WIDTH-1:0]  old_a, old_b;
  logic [WIDTH-1:0]  douta_s1, doutb_s1, douta_s1_nxt, doutb_s1_nxt;
  logic              coll_det, coll_s1, coll_evt;

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] din,
                                             input logic [NB-1:0]    we);
    logic [WIDTH-1:0] w;
    w = old;
    for (int i = 0; i < NB; i++)
      if (we[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  // Next stage-1 read value for one port; cur is returned when the port holds.
  function automatic logic [WIDTH-1:0] rd_next(input logic             en,
                                               input logic             ok,
                                               input logic [NB-1:0]    we,
                                               input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] old,
                                               input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] r;
    r = cur;
    if (en) begin
      if (we == '0) begin
        r = ok ? old : '0;
      end else begin
        case (RD_MODE)
          0:       r = ok ? old : '0;
          1:       r = ok ? merge(old, din, we) : '0;
          default: r = cur;
        endcase
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST) begin
        state_nxt = S_RUN;
        cnt_nxt   = '0;
      end
    end
  end

  assign run       = (state == S_RUN);
  assign init_busy = ~run;

  assign a_ok  = ({1'b0, addra} < DEPTH_L);
  assign b_ok  = ({1'b0, addrb} < DEPTH_L);
  assign wr_a  = run & ena & a_ok & (|wea);
  assign wr_b  = run & enb & b_ok & (|web);
  assign old_a = a_ok ? mem[addra] : '0;
  assign old_b = b_ok ? mem[addrb] : '0;

  assign coll_det = run & ena & enb & a_ok & b_ok & (addra == addrb) & ((|wea) | (|web));

  // Port A lanes are written after port B so A wins on shared lanes.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_b && web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
        if (wr_a && wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  assign douta_s1_nxt = rd_next(run & ena, a_ok, wea, douta_s1, old_a, dina);
  assign doutb_s1_nxt = rd_next(run & enb, b_ok, web, doutb_s1, old_b, dinb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_s1 <= '0;
      doutb_s1 <= '0;
      coll_s1  <= 1'b0;
    end else begin
      douta_s1 <= douta_s1_nxt;
      doutb_s1 <= doutb_s1_nxt;
      coll_s1  <= coll_det;
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic [WIDTH-1:0] douta_q, doutb_q;
  logic             coll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      douta_q <= '0;
      doutb_q <= '0;
      coll_q  <= 1'b0;
    end else begin
      douta_q <= douta_s1;
      doutb_q <= doutb_s1;
      coll_q  <= coll_s1;
    end
  end

  assign douta    = douta_q;
  assign doutb    = doutb_q;
  assign coll     = coll_q;
  assign coll_evt = coll_s1;
`else
  assign douta    = douta_s1;
  assign doutb    = doutb_s1;
  assign coll     = coll_s1;
  assign coll_evt = coll_det;
`endif

  // Counter steps on the same edge that raises coll.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (coll_evt && coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end

endmodule
